// File: rtl/periph_pkg.sv
// periph_pkg: shared state encoding and default peripheral-window constants
package periph_pkg;
  typedef enum logic [1:0] {IDLE, REQ, DONE} pbus_state_t;
  localparam logic [63:0] DEF_BASE = 64'h2000_0000;
  localparam int DEF_N_SLOTS = 4;
  localparam int DEF_SLOT_SHIFT = 12;
  localparam int DEF_TIMEOUT = 255;
  function automatic int slot_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int SLOT_W = slot_w(DEF_N_SLOTS);
endpackage

// File: rtl/periph_addr_decode.sv
// periph_addr_decode: maps a byte address to peripheral slot, in-slot offset and range flag
module periph_addr_decode import periph_pkg::*; #(
  parameter logic [63:0] BASE = DEF_BASE,
  parameter int N_SLOTS = DEF_N_SLOTS,
  parameter int SLOT_SHIFT = DEF_SLOT_SHIFT,
  parameter int SW = slot_w(N_SLOTS)
) (
  input  logic [63:0]           addr,
  output logic [SW-1:0]         slot,
  output logic [SLOT_SHIFT-1:0] offset,
  output logic                  in_range
);
  logic [63:0] diff, idx;
  assign diff = addr - BASE;
  assign idx = diff >> SLOT_SHIFT;
  assign slot = idx[SW-1:0];
  assign offset = diff[SLOT_SHIFT-1:0];
  // addresses below BASE wrap to huge indices and land out of range
  assign in_range = idx < 64'(N_SLOTS);
endmodule

// File: rtl/periph_bus_ctrl.sv
// periph_bus_ctrl: one-at-a-time sequencer of core accesses onto the multi-slot peripheral bus
// Optional ack timeout enabled by defining PERIPH_TIMEOUT_EN.
module periph_bus_ctrl import periph_pkg::*; #(
  parameter logic [63:0] PERIPHERAL_BASE = DEF_BASE,
  parameter int N_SLOTS = DEF_N_SLOTS,
  parameter int SLOT_SHIFT = DEF_SLOT_SHIFT,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    d_valid,
  input  logic [63:0]             d_addr,
  input  logic                    d_write,
  input  logic [63:0]             d_wdata,
  input  logic [7:0]              d_be,
  output logic                    d_ready,
  output logic [63:0]             d_rdata,
  output logic                    d_err,
  output logic [N_SLOTS-1:0]      p_req,
  output logic [SLOT_SHIFT-1:0]   p_addr,
  output logic                    p_we,
  output logic [63:0]             p_wdata,
  output logic [7:0]              p_be,
  input  logic [N_SLOTS-1:0]      p_ack,
  input  logic [N_SLOTS*64-1:0]   p_rdata
);
  localparam int SW = slot_w(N_SLOTS);
  pbus_state_t state;
  logic [SW-1:0] slot, slot_q;
  logic [SLOT_SHIFT-1:0] offset;
  logic in_range, ack, expired;
  periph_addr_decode #(
    .BASE(PERIPHERAL_BASE), .N_SLOTS(N_SLOTS), .SLOT_SHIFT(SLOT_SHIFT), .SW(SW)
  ) u_dec (
    .addr(d_addr), .slot(slot), .offset(offset), .in_range(in_range)
  );
  assign ack = p_ack[slot_q];
`ifdef PERIPH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  assign expired = cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= (state == REQ) ? cnt + 1'b1 : '0;
`else
  assign expired = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      slot_q <= '0;
      d_ready <= 1'b0;
      d_err <= 1'b0;
      d_rdata <= '0;
      p_req <= '0;
      p_addr <= '0;
      p_we <= 1'b0;
      p_wdata <= '0;
      p_be <= '0;
    end else begin
      case (state)
        IDLE: if (d_valid) begin
          if (in_range) begin
            state <= REQ;
            slot_q <= slot;
            p_req <= N_SLOTS'(1) << slot;
            p_addr <= offset;
            p_we <= d_write;
            p_wdata <= d_wdata;
            p_be <= d_be;
          end else begin
            state <= DONE;
            d_ready <= 1'b1;
            d_err <= 1'b1;
            d_rdata <= '0;
          end
        end
        REQ: if (ack || expired) begin
          state <= DONE;
          p_req <= '0;
          d_ready <= 1'b1;
          d_err <= !ack;
          d_rdata <= (ack && !p_we) ? p_rdata[{slot_q, 6'd0} +: 64] : '0;
        end
        DONE: begin
          state <= IDLE;
          d_ready <= 1'b0;
          d_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_periph_bus_ctrl.sv
// tb_periph_bus_ctrl: directed and randomized checks of periph_bus_ctrl against an address/latency model
module tb_periph_bus_ctrl;
  localparam logic [63:0] BASE = 64'h2000_0000;
  localparam int NS = 4;
  localparam int TO = 8;
  logic clk = 0, reset = 0, d_valid = 0, d_write = 0, d_ready, d_err, p_we;
  logic [63:0] d_addr = 0, d_wdata = 0, d_rdata, p_wdata;
  logic [7:0] d_be = 0, p_be;
  logic [NS-1:0] p_req, p_ack = 0;
  logic [11:0] p_addr;
  logic [NS*64-1:0] p_rdata = 0;
  int n_chk = 0, n_fail = 0;
  periph_bus_ctrl #(.PERIPHERAL_BASE(BASE), .N_SLOTS(NS), .SLOT_SHIFT(12), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_addr(d_addr), .d_write(d_write),
    .d_wdata(d_wdata), .d_be(d_be), .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
    .p_req(p_req), .p_addr(p_addr), .p_we(p_we), .p_wdata(p_wdata), .p_be(p_be),
    .p_ack(p_ack), .p_rdata(p_rdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Called at a negedge; drives one access and follows it to retirement.
  task automatic access(input logic [63:0] addr, input logic wr, input logic [63:0] wd,
                        input logic [7:0] be, input int k, input logic [NS-1:0] stray);
    logic [63:0] diff, idx, rd;
    logic [NS-1:0] sel;
    diff = addr - BASE;
    idx = diff >> 12;
    d_addr = addr; d_write = wr; d_wdata = wd; d_be = be; d_valid = 1;
    @(negedge clk);
    if (idx >= 64'(NS)) begin
      chk("bad_ready", 64'(d_ready), 1);
      chk("bad_err", 64'(d_err), 1);
      chk("bad_rdata", d_rdata, 0);
      chk("bad_preq", 64'(p_req), 0);
    end else begin
      sel = NS'(1) << idx;
      rd = wr ? 64'h0 : p_rdata[64*int'(idx) +: 64];
      chk("req_onehot", 64'(p_req), 64'(sel));
      chk("req_addr", 64'(p_addr), 64'(diff[11:0]));
      chk("req_we", 64'(p_we), 64'(wr));
      chk("req_be", 64'(p_be), 64'(be));
      chk("req_wdata", p_wdata, wd);
      for (int j = 0; j <= k; j++) begin
        p_ack = (j == k) ? sel : (stray & ~sel);
        @(negedge clk);
        if (j < k) begin
          chk("wait_ready", 64'(d_ready), 0);
          chk("wait_req", 64'(p_req), 64'(sel));
        end
      end
      chk("done_ready", 64'(d_ready), 1);
      chk("done_err", 64'(d_err), 0);
      chk("done_rdata", d_rdata, rd);
      chk("done_preq", 64'(p_req), 0);
    end
    p_ack = 0; d_valid = 0;
    @(negedge clk);
    chk("ready_pulse", 64'(d_ready), 0);
  endtask
  initial begin
    logic [63:0] a;
    logic bad;
    #1 reset = 1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(d_ready), 0);
    chk("rst_err", 64'(d_err), 0);
    chk("rst_rdata", d_rdata, 0);
    chk("rst_preq", 64'(p_req), 0);
    chk("rst_pfields", {p_wdata[31:0], 8'(p_be), 11'(p_addr), p_we}, 0);
    reset = 0;
    @(negedge clk);
    p_rdata[127:64] = 64'hDEAD_BEEF;
    access(64'h2000_1010, 0, 0, 8'hFF, 1, 0);
    access(64'h2000_3008, 1, 64'h55, 8'h01, 0, 0);
    access(64'h2000_8000, 0, 0, 8'hFF, 0, 0);
    p_rdata[191:128] = 64'h0123_4567_89AB_CDEF;
    access(64'h2000_2000, 0, 0, 8'hF0, 3, 4'b0001);
    for (int i = 0; i < 24; i++) begin
      for (int s = 0; s < NS; s++) p_rdata[64*s +: 64] = {$urandom, $urandom};
      a = BASE + (64'($urandom_range(0, 5)) << 12) + 64'($urandom_range(0, 4095));
      if ($urandom_range(0, 7) == 0) a = BASE - 64'($urandom_range(1, 4096));
      access(a, 1'($urandom), {$urandom, $urandom}, 8'($urandom), $urandom_range(0, 4), 4'($urandom));
    end
    d_addr = 64'h2000_0040; d_write = 0; d_valid = 1;
    @(negedge clk);
    chk("to_req", 64'(p_req), 1);
`ifdef PERIPH_TIMEOUT_EN
    bad = 0;
    for (int j = 1; j < TO; j++) begin
      @(negedge clk);
      if (p_req !== 4'b0001 || d_ready !== 1'b0) bad = 1;
    end
    chk("to_hold", 64'(bad), 0);
    @(negedge clk);
    chk("to_ready", 64'(d_ready), 1);
    chk("to_err", 64'(d_err), 1);
    chk("to_rdata", d_rdata, 0);
    chk("to_preq", 64'(p_req), 0);
    d_valid = 0;
    @(negedge clk);
`else
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (p_req !== 4'b0001 || d_ready !== 1'b0) bad = 1;
    end
    chk("no_timeout", 64'(bad), 0);
    reset = 1; d_valid = 0;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
`endif
    d_addr = 64'h2000_3100; d_write = 0; d_valid = 1;
    repeat (2) @(negedge clk);
    chk("rst_mid_req", 64'(p_req), 64'b1000);
    reset = 1; d_valid = 0;
    #1;
    chk("rst_drop_req", 64'(p_req), 0);
    chk("rst_no_ready", 64'(d_ready), 0);
    @(negedge clk);
    reset = 0;
    p_ack = 4'b1111;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (d_ready !== 1'b0 || p_req !== 4'b0000) bad = 1;
    end
    chk("rst_abandon", 64'(bad), 0);
    p_ack = 0;
    p_rdata[255:192] = 64'hCAFE_F00D_1234_5678;
    access(64'h2000_3FF8, 0, 0, 8'hFF, 1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
